// File: rtl/pif_ram_pkg.sv
// Shared definitions for the PIF RAM port-A arbiter: widths, requester ids, FSM encoding.
package pif_ram_pkg;

    localparam int PIF_ADDR_W = 11;
    localparam int PIF_DATA_W = 8;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_SI  = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        ACK     = 2'd3
    } pif_state_e;

endpackage

// File: rtl/pif_ram_port_a_arbiter_if.sv
// Byte-wide RAM port-A bus; master is the arbiter, slave is the RAM.
interface pif_ram_port_a_arbiter_if
    import pif_ram_pkg::*;
#(
    parameter int ADDR_W = PIF_ADDR_W,
    parameter int DATA_W = PIF_DATA_W
) ();

    logic [ADDR_W-1:0] ram_address_a;
    logic              ram_wren_a;
    logic [DATA_W-1:0] ram_data_a;
    logic              ram_oe;
    logic [DATA_W-1:0] ram_q_a;
    logic              ram_valid;

    // Strobes (wren/oe) are single-cycle; valid answers oe one cycle later with q_a.
    modport master (
        output ram_address_a, ram_wren_a, ram_data_a, ram_oe,
        input  ram_q_a, ram_valid
    );

    modport slave (
        input  ram_address_a, ram_wren_a, ram_data_a, ram_oe,
        output ram_q_a, ram_valid
    );

endinterface

// File: rtl/pif_rr_pick2.sv
// Two-way request pick: round-robin against last_grant on conflict, or fixed priority to req 0.
module pif_rr_pick2
    import pif_ram_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);

    always_comb begin
        grant_valid = req0 | req1;
        grant       = REQ_CPU;
        if (req0 && req1) begin
            grant = (ROUND_ROBIN != 0) ? ~last_grant : REQ_CPU;
        end else if (req1) begin
            grant = REQ_SI;
        end
    end

endmodule

// File: rtl/pif_ram_port_a_arbiter.sv
// Serialises boot-CPU and SI accesses onto PIF RAM port A, sequencing strobes, read capture and timeout.
module pif_ram_port_a_arbiter
    import pif_ram_pkg::*;
#(
    parameter int ADDR_W      = PIF_ADDR_W,
    parameter int DATA_W      = PIF_DATA_W,
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output pif_state_e        state_dbg,
    pif_ram_port_a_arbiter_if.master ram
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    pif_state_e       state, state_n;
    logic             owner;
    logic             we_q;
    logic             err_q;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;

    logic grant_valid;
    logic grant;
    logic load;
    logic capture;
    logic timeout;
    logic cnt_inc;

    logic              we_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;

    pif_rr_pick2 #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    assign we_sel    = (grant == REQ_SI) ? we1    : we0;
    assign addr_sel  = (grant == REQ_SI) ? addr1  : addr0;
    assign wdata_sel = (grant == REQ_SI) ? wdata1 : wdata0;

    always_comb begin
        state_n = state;
        load    = 1'b0;
        capture = 1'b0;
        timeout = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    load    = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                state_n = we_q ? ACK : RD_WAIT;
            end
            RD_WAIT: begin
                if (ram.ram_valid) begin
                    capture = 1'b1;
                    state_n = ACK;
                end else if (cnt == TMO_LAST) begin
                    timeout = 1'b1;
                    state_n = ACK;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ACK: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            owner             <= REQ_CPU;
            we_q              <= 1'b0;
            err_q             <= 1'b0;
            last_grant        <= REQ_SI;
            cnt               <= '0;
            rdata             <= '0;
            ram.ram_address_a <= '0;
            ram.ram_data_a    <= '0;
            ram.ram_wren_a    <= 1'b0;
            ram.ram_oe        <= 1'b0;
        end else begin
            state          <= state_n;
            // Strobes default low so they only last the ISSUE cycle.
            ram.ram_wren_a <= 1'b0;
            ram.ram_oe     <= 1'b0;
            if (load) begin
                owner             <= grant;
                we_q              <= we_sel;
                last_grant        <= grant;
                ram.ram_address_a <= addr_sel;
                ram.ram_data_a    <= wdata_sel;
                ram.ram_wren_a    <= we_sel;
                ram.ram_oe        <= ~we_sel;
            end
            if (state == ISSUE) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
            if (capture) begin
                rdata <= ram.ram_q_a;
            end
            if (timeout) begin
                rdata <= '0;
                err_q <= 1'b1;
            end
            if (state == ACK) begin
                err_q <= 1'b0;
            end
        end
    end

    assign ack0      = (state == ACK) && (owner == REQ_CPU);
    assign ack1      = (state == ACK) && (owner == REQ_SI);
    assign err0      = ack0 && err_q;
    assign err1      = ack1 && err_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_pif_ram_port_a_arbiter.sv
// Bench for the port-A arbiter: RAM models with one-cycle valid, scoreboard of expected acks.
module tb_pif_ram_port_a_arbiter;
  import pif_ram_pkg::*;

  logic clk = 1'b0;
  logic reset;

  // round-robin instance
  logic        req0, req1, we0, we1;
  logic [10:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [7:0]  rdata;
  pif_state_e  state_dbg;

  // fixed-priority instance
  logic        req0_f, req1_f, we0_f, we1_f;
  logic [10:0] addr0_f, addr1_f;
  logic [7:0]  wdata0_f, wdata1_f;
  logic        ack0_f, ack1_f, err0_f, err1_f;
  logic [7:0]  rdata_f;
  pif_state_e  state_dbg_f;

  pif_ram_port_a_arbiter_if ram_a ();
  pif_ram_port_a_arbiter_if ram_f ();

  logic [7:0] mem_a [2048];
  logic [7:0] mem_f [2048];
  logic [7:0] shadow [2048];
  logic       valid_kill;

  int checks = 0;
  int errors = 0;
  // entry = {is_read, owner, err, rdata}
  logic [10:0] exp_q[$];
  logic [10:0] sb_e, sb_got;

  pif_ram_port_a_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata(rdata), .state_dbg(state_dbg), .ram(ram_a)
  );

  pif_ram_port_a_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(4)) dut_f (
    .clk(clk), .reset(reset),
    .req0(req0_f), .req1(req1_f), .we0(we0_f), .we1(we1_f),
    .addr0(addr0_f), .addr1(addr1_f), .wdata0(wdata0_f), .wdata1(wdata1_f),
    .ack0(ack0_f), .ack1(ack1_f), .err0(err0_f), .err1(err1_f),
    .rdata(rdata_f), .state_dbg(state_dbg_f), .ram(ram_f)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired got no_finish exp finish");
    $fatal(1);
  end

  // RAM models: registered q_a and valid one cycle after oe
  always @(posedge clk) begin
    if (reset) begin
      ram_a.ram_valid <= 1'b0;
      ram_a.ram_q_a   <= 8'h00;
    end else begin
      if (ram_a.ram_wren_a) mem_a[ram_a.ram_address_a] <= ram_a.ram_data_a;
      if (ram_a.ram_oe && !valid_kill) begin
        ram_a.ram_q_a   <= mem_a[ram_a.ram_address_a];
        ram_a.ram_valid <= 1'b1;
      end else begin
        ram_a.ram_valid <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      ram_f.ram_valid <= 1'b0;
      ram_f.ram_q_a   <= 8'h00;
    end else begin
      if (ram_f.ram_wren_a) mem_f[ram_f.ram_address_a] <= ram_f.ram_data_a;
      ram_f.ram_q_a   <= mem_f[ram_f.ram_address_a];
      ram_f.ram_valid <= ram_f.ram_oe;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (ack0 && ack1) begin
        checks++;
        errors++;
        $display("FAIL ack_excl got ack0=1 ack1=1 exp at most one");
      end
      if (ack0 || ack1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_empty got ack0=%0b ack1=%0b exp no ack", ack0, ack1);
        end else begin
          sb_e   = exp_q.pop_front();
          sb_got = {sb_e[10], ack1, err0 | err1, sb_e[10] ? rdata : 8'h00};
          if (sb_got !== sb_e) begin
            errors++;
            $display("FAIL sb_ack got rd=%0b owner=%0b err=%0b data=%02h exp rd=%0b owner=%0b err=%0b data=%02h",
                     sb_got[10], sb_got[9], sb_got[8], sb_got[7:0], sb_e[10], sb_e[9], sb_e[8], sb_e[7:0]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic start_req(input int who, input logic we, input logic [10:0] addr, input logic [7:0] data);
    if (who == 0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = data;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = data;
    end
  endtask

  task automatic stop_req(input int who);
    @(posedge clk);
    #1;
    if (who == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  task automatic push_exp(input int who, input logic we, input logic [10:0] addr, input logic [7:0] data,
                          input logic err);
    logic [7:0] d;
    if (we) begin
      shadow[addr] = data;
      exp_q.push_back({1'b0, who[0], 1'b0, 8'h00});
    end else begin
      d = err ? 8'h00 : shadow[addr];
      exp_q.push_back({1'b1, who[0], err, d});
    end
  endtask

  task automatic wait_ack(input int who, input int budget, output int lat);
    lat = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (who == 0 ? ack0 : ack1) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout who=%0d got no_ack exp ack within %0d cycles", who, budget);
    end
  endtask

  task automatic check_lat(input string name, input int lat, input int exp_lat);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency got %0d exp %0d", name, lat, exp_lat);
    end
  endtask

  // scenarios
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ack0, ack1, err0, err1, rdata, ram_a.ram_address_a, ram_a.ram_data_a,
         ram_a.ram_wren_a, ram_a.ram_oe} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ack=%0b%0b err=%0b%0b rdata=%02h addr=%03h wren=%0b oe=%0b exp all 0",
               ack0, ack1, err0, err1, rdata, ram_a.ram_address_a, ram_a.ram_wren_a, ram_a.ram_oe);
    end
    checks++;
    if (state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d exp %0d", state_dbg, IDLE);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_write_read;
    int lat;
    start_req(1, 1'b1, 11'h7C1, 8'hA5);
    push_exp(1, 1'b1, 11'h7C1, 8'hA5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ram_a.ram_wren_a, ram_a.ram_oe, ram_a.ram_address_a, ram_a.ram_data_a} !== {1'b1, 1'b0, 11'h7C1, 8'hA5}) begin
      errors++;
      $display("FAIL wr_issue got wren=%0b oe=%0b addr=%03h data=%02h exp wren=1 oe=0 addr=7c1 data=a5",
               ram_a.ram_wren_a, ram_a.ram_oe, ram_a.ram_address_a, ram_a.ram_data_a);
    end
    @(negedge clk);
    checks++;
    if ({ack0, ack1} !== 2'b01) begin
      errors++;
      $display("FAIL wr_ack_cycle2 got ack0=%0b ack1=%0b exp ack0=0 ack1=1", ack0, ack1);
    end
    stop_req(1);
    start_req(0, 1'b0, 11'h7C1, 8'h00);
    push_exp(0, 1'b0, 11'h7C1, 8'h00, 1'b0);
    wait_ack(0, 10, lat);
    check_lat("rd_7c1", lat, 3);
    checks++;
    if (rdata !== 8'hA5) begin
      errors++;
      $display("FAIL rd_7c1_data got %02h exp a5", rdata);
    end
    stop_req(0);
  endtask

  task automatic test_round_robin;
    int lat;
    start_req(0, 1'b1, 11'h100, 8'h3C);
    push_exp(0, 1'b1, 11'h100, 8'h3C, 1'b0);
    wait_ack(0, 10, lat);
    stop_req(0);
    // simultaneous reads: last_grant was CPU, but the first-ever conflict rule is checked below
    start_req(0, 1'b0, 11'h7C1, 8'h00);
    start_req(1, 1'b0, 11'h100, 8'h00);
    push_exp(1, 1'b0, 11'h100, 8'h00, 1'b0);
    push_exp(0, 1'b0, 11'h7C1, 8'h00, 1'b0);
    wait_ack(1, 10, lat);
    check_lat("rr_first_si", lat, 3);
    stop_req(1);
    wait_ack(0, 10, lat);
    check_lat("rr_then_cpu", lat, 3);
    // cpu keeps its request up: si now wins the conflict, cpu follows
    start_req(1, 1'b0, 11'h100, 8'h00);
    push_exp(1, 1'b0, 11'h100, 8'h00, 1'b0);
    push_exp(0, 1'b0, 11'h7C1, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    wait_ack(1, 10, lat);
    check_lat("rr_held_si", lat, 3);
    stop_req(1);
    wait_ack(0, 10, lat);
    check_lat("rr_held_cpu", lat, 3);
    stop_req(0);
    // fresh write conflict after a CPU grant: SI first
    start_req(0, 1'b1, 11'h200, 8'h77);
    start_req(1, 1'b1, 11'h201, 8'h88);
    push_exp(1, 1'b1, 11'h201, 8'h88, 1'b0);
    push_exp(0, 1'b1, 11'h200, 8'h77, 1'b0);
    wait_ack(1, 10, lat);
    check_lat("rr_wr_si", lat, 2);
    stop_req(1);
    wait_ack(0, 10, lat);
    check_lat("rr_wr_cpu", lat, 2);
    stop_req(0);
  endtask

  task automatic test_first_conflict;
    int lat;
    // after reset last_grant = SI, so CPU wins the first conflict
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start_req(0, 1'b0, 11'h200, 8'h00);
    start_req(1, 1'b0, 11'h201, 8'h00);
    push_exp(0, 1'b0, 11'h200, 8'h00, 1'b0);
    push_exp(1, 1'b0, 11'h201, 8'h00, 1'b0);
    wait_ack(0, 10, lat);
    check_lat("first_conf_cpu", lat, 3);
    stop_req(0);
    wait_ack(1, 10, lat);
    check_lat("first_conf_si", lat, 3);
    stop_req(1);
  endtask

  task automatic test_timeout;
    int lat;
    valid_kill = 1'b1;
    start_req(0, 1'b0, 11'h7C1, 8'h00);
    push_exp(0, 1'b0, 11'h7C1, 8'h00, 1'b1);
    wait_ack(0, 20, lat);
    check_lat("timeout", lat, 6);
    checks++;
    if ({err0, err1, rdata} !== {1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL timeout_err got err0=%0b err1=%0b rdata=%02h exp err0=1 err1=0 rdata=00", err0, err1, rdata);
    end
    stop_req(0);
    valid_kill = 1'b0;
  endtask

  task automatic test_reset_mid;
    int lat;
    start_req(1, 1'b1, 11'h000, 8'h5A);
    push_exp(1, 1'b1, 11'h000, 8'h5A, 1'b0);
    wait_ack(1, 10, lat);
    stop_req(1);
    valid_kill = 1'b1;
    start_req(0, 1'b0, 11'h000, 8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if (state_dbg !== RD_WAIT) begin
      errors++;
      $display("FAIL mid_rd_wait got %0d exp %0d", state_dbg, RD_WAIT);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({state_dbg, ram_a.ram_oe, ack0, err0} !== {IDLE, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset got state=%0d oe=%0b ack0=%0b err0=%0b exp state=0 oe=0 ack0=0 err0=0",
               state_dbg, ram_a.ram_oe, ack0, err0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    req0 = 1'b0;
    valid_kill = 1'b0;
    start_req(0, 1'b0, 11'h000, 8'h00);
    push_exp(0, 1'b0, 11'h000, 8'h00, 1'b0);
    wait_ack(0, 10, lat);
    check_lat("after_reset_rd", lat, 3);
    checks++;
    if (rdata !== 8'h5A) begin
      errors++;
      $display("FAIL after_reset_data got %02h exp 5a", rdata);
    end
    stop_req(0);
  endtask

  task automatic test_byte_lanes;
    int lat;
    logic [7:0]  b;
    logic [10:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 11'h010 + 11'(i);
      b = 8'(8'h11 * (i + 1));
      start_req(1, 1'b1, a, b);
      push_exp(1, 1'b1, a, b, 1'b0);
      wait_ack(1, 10, lat);
      stop_req(1);
    end
    checks++;
    if ({mem_a[11'h013], mem_a[11'h012], mem_a[11'h011], mem_a[11'h010]} !== 32'h44332211) begin
      errors++;
      $display("FAIL port_b_word4 got %02h%02h%02h%02h exp 44332211",
               mem_a[11'h013], mem_a[11'h012], mem_a[11'h011], mem_a[11'h010]);
    end
    for (int i = 0; i < 4; i++) begin
      a = 11'h010 + 11'(i);
      b = 8'(8'h11 * (i + 1));
      start_req(0, 1'b0, a, 8'h00);
      push_exp(0, 1'b0, a, 8'h00, 1'b0);
      wait_ack(0, 10, lat);
      checks++;
      if (rdata !== b) begin
        errors++;
        $display("FAIL lane_rd%0d got %02h exp %02h", i, rdata, b);
      end
      stop_req(0);
    end
  endtask

  task automatic test_fixed_priority;
    int acks0, saw1, lat;
    acks0 = 0;
    saw1  = 0;
    req0_f = 1'b1; we0_f = 1'b0; addr0_f = 11'h005; wdata0_f = 8'h00;
    req1_f = 1'b1; we1_f = 1'b1; addr1_f = 11'h006; wdata1_f = 8'h99;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ack1_f) saw1++;
      if (ack0_f) acks0++;
    end
    checks++;
    if (saw1 !== 0 || acks0 !== 10) begin
      errors++;
      $display("FAIL fixed_starve got ack1=%0d ack0=%0d exp ack1=0 ack0=10", saw1, acks0);
    end
    @(posedge clk);
    #1;
    req0_f = 1'b0;
    lat = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ack0_f) saw1 = saw1 + 100;
      if (ack1_f) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat !== 2 || saw1 !== 0) begin
      errors++;
      $display("FAIL fixed_release got lat=%0d stray=%0d exp lat=2 stray=0", lat, saw1);
    end
    checks++;
    if (mem_f[11'h006] !== 8'h99) begin
      errors++;
      $display("FAIL fixed_wr_data got %02h exp 99", mem_f[11'h006]);
    end
    @(posedge clk);
    #1;
    req1_f = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    valid_kill = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    req0_f = 1'b0; req1_f = 1'b0; we0_f = 1'b0; we1_f = 1'b0;
    addr0_f = '0; addr1_f = '0; wdata0_f = '0; wdata1_f = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_first_conflict();
    test_timeout();
    test_reset_mid();
    test_byte_lanes();
    test_fixed_priority();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
